fp_accumulator: RTL and testbench
=================================

# fp_accumulator

Sequential single-precision floating-point accumulator that sits directly downstream of the floating-point multiplier. It consumes the multiplier's product words (and overflow flags) over a valid/ready stream and sums a burst of products, terminated by `in_last`. It returns one 32-bit sum per burst, which gives the datapath its multiply-accumulate (dot-product) capability. It uses an iterative four-cycle-per-element FSM.

## Interface
- `N`, default 32: word width; only 32 is supported (1 sign, 8 exponent, 23 mantissa bits).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `enable`, input, 1: when low, FSM and all registers freeze, `in_ready` is forced low, and outputs hold.
- `in_valid`, input, 1: `in_data`/`in_overflow`/`in_last` are valid.
- `in_ready`, output, 1: the block accepts an element this cycle.
- `in_data`, input, N: product word.
- `in_overflow`, input, 1: the producer flagged overflow on this element.
- `in_last`, input, 1: final element of the burst.
- `out_valid`, output, 1: `result`/`overflow` hold a completed burst sum.
- `out_ready`, input, 1: consumer takes the result.
- `result`, output, N: accumulated sum.
- `overflow`, output, 1: sticky overflow for the reported burst.

## Operation
- States: IDLE, ALIGN, ADD, NORM, DONE.
- **IDLE**
  - `in_ready=1` (if `enable`).
  - A transfer occurs when `in_valid & in_ready`. It latches the operand, `in_last`, and ORs `in_overflow` into the sticky flag, then moves to ALIGN.
- **ALIGN**
  - Operand B is the input; operand A is the accumulator.
  - A word with exponent field 0 is treated as zero (flush), including any mantissa.
  - Mantissas are 24 bits with hidden 1.
  - Larger = greater {exp, mantissa}; ties select the accumulator.
  - Shift the smaller mantissa right by the exponent difference. A difference ≥ 25 gives 0. Shifted-out bits are truncated.
- **ADD**
  - Same signs: add into a 25-bit sum. Different signs: larger minus smaller.
  - Result sign = sign of the larger operand.
- **NORM**
  - Carry (bit 24) set: shift right 1 and exp+1.
  - Otherwise shift left by the leading-zero count of the 24-bit value and subtract that count from exp.
  - Zero mantissa, or exp−lz < 1: the accumulator becomes 0x00000000 (sign 0).
  - Exponent reaching ≥255: accumulator = {sign, 8'hFF, 23'h0} and the sticky overflow flag is set. Once saturated, later elements of the burst are consumed but leave the accumulator unchanged.
  - Exit: `in_last` latched goes to DONE, otherwise IDLE.
- **DONE**
  - `out_valid=1`, `result`=accumulator, `overflow`=sticky flag. `in_ready=0`.
  - On `out_ready`: clear accumulator to 0 and the sticky flag, then go to IDLE.
- No rounding; truncation only.
- An empty burst is impossible; each burst contains ≥1 element.

## Timing
- Reset values: state IDLE, accumulator 0, `result`=0, `overflow`=0, `out_valid`=0, `in_ready`=0 while `reset` is high, then 1 in IDLE.
- Per element: accept at cycle t; ALIGN t+1, ADD t+2, NORM t+3; next accept is possible at t+4. Throughput is 1 element per 4 cycles.
- The last element accepted at t gives `out_valid` high from t+4.
- `result`/`overflow` are stable while `out_valid` is high and `out_ready` is low. The handshake completes on the cycle both are high.
- `in_ready` is combinational from state and `enable` only; it never depends on `in_valid`.
- `enable` low mid-element: the element resumes at the same stage when `enable` returns. No data is lost and no extra handshake occurs.
- `reset` mid-burst or in DONE: the partial sum is discarded, `out_valid` drops immediately, and the block returns to IDLE.
- `in_overflow` on any element makes `overflow=1` for that burst's result, even if the sum itself is finite.

## Test plan
- Burst {0x3F800000, 0x40000000 last} → `result` = 0x40400000, `overflow`=0, `out_valid` 8 cycles after the first accept.
- Burst {0x3F800000, 0xBF800000 last} → `result` = 0x00000000 (positive zero).
- Burst {0x4B800000, 0x3F800000 last} (alignment truncation) → `result` = 0x4B800000. Single burst {0x3FC00000 last} → 0x3FC00000.
- Burst {0x7F000000, 0x7F000000, 0x3F800000 last} → `result` = 0x7F800000, `overflow`=1. A following burst {0x3F800000 last} → 0x3F800000 with `overflow`=0 (sticky cleared).
- Backpressure: hold `out_ready` low for 5 cycles in DONE → `out_valid`/`result` stay constant and `in_ready`=0. Toggle `enable` low for 3 cycles during ADD → same final result, with latency extended by 3.
- Assert `reset` for one cycle during NORM of a 3-element burst → outputs return to reset values. A new burst {0x40000000 last} → 0x40000000.

Source files
------------

// File: rtl/fp_accumulator_if.sv
// Stream bundle between the multiplier (producer), the accumulator and the
// downstream consumer of burst sums.
//   in_valid/in_ready   : element handshake (producer -> accumulator)
//   in_data             : product word (IEEE-754 single layout)
//   in_overflow         : producer flagged overflow on this element
//   in_last             : element closes the burst
//   out_valid/out_ready : burst-sum handshake (accumulator -> consumer)
//   result              : accumulated sum
//   overflow            : sticky overflow of the reported burst
// master = testbench/system side, slave = accumulator side.
interface fp_accumulator_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_overflow;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         overflow;

  modport master (
    output in_valid, in_data, in_overflow, in_last, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, in_data, in_overflow, in_last, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/fp_accumulator.sv
// Iterative single-precision accumulator. Sums a burst of product words
// (terminated by in_last) with a four-state-per-element FSM
// (IDLE accept, ALIGN, ADD, NORM) and presents one sum per burst in DONE.
// Exponent-0 words are flushed to zero; no rounding (truncation only);
// exponent overflow saturates the burst to signed infinity.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears all state
//   enable : freezes FSM and registers when low, forces in_ready low
//   bus    : fp_accumulator_if.slave stream bundle (see interface file)
module fp_accumulator #(
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  fp_accumulator_if.slave        bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t       state_q;
  logic [N-1:0] acc_q;        // running sum, also drives result
  logic [N-1:0] op_q;         // latched input operand
  logic         last_q;
  logic         ovf_q;        // sticky overflow for the current burst
  logic         sat_q;        // accumulator saturated; ignore further elements
  logic         out_valid_q;

  // ALIGN -> ADD registers
  logic         sgn_big_q;
  logic         sgn_sml_q;
  logic [7:0]   exp_big_q;
  logic [23:0]  man_big_q;
  logic [23:0]  man_sml_q;

  // ADD -> NORM register
  logic [24:0]  sum_q;

  // Leading-zero count of a 24-bit value (24 when zero).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Normalise a 25-bit magnitude to a packed word, with underflow flush and
  // overflow saturation. Bit 32 of the return value flags saturation.
  function automatic logic [32:0] norm_sat(input logic        sign,
                                           input logic [7:0]  exp_l,
                                           input logic [24:0] sum);
    logic signed [9:0] e;
    logic [23:0]       m;
    logic [4:0]        lz;
    if (sum[24]) begin
      m = sum[24:1];
      e = $signed({2'b00, exp_l}) + 10'sd1;
    end else if (sum[23:0] == 24'd0) begin
      return 33'd0;
    end else begin
      lz = lzc24(sum[23:0]);
      m  = sum[23:0] << lz;
      e  = $signed({2'b00, exp_l}) - $signed({5'b00000, lz});
    end
    if (e < 10'sd1)   return 33'd0;
    if (e >= 10'sd255) return {1'b1, sign, 8'hFF, 23'h000000};
    return {1'b0, sign, e[7:0], m[22:0]};
  endfunction

  // Operand selection and alignment (evaluated while in ALIGN)
  logic [7:0]  exp_a, exp_b, exp_big, exp_sml, exp_diff;
  logic [23:0] man_a, man_b, man_big, man_sml, man_sml_sh;
  logic        a_big, sgn_big, sgn_sml;

  always_comb begin
    exp_a = acc_q[30:23];
    exp_b = op_q[30:23];
    man_a = (exp_a == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
    man_b = (exp_b == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
    // ties go to the accumulator so x + (-x) takes the accumulator's sign path
    a_big = ({exp_a, man_a} >= {exp_b, man_b});
    if (a_big) begin
      exp_big = exp_a;  man_big = man_a;  sgn_big = acc_q[31];
      exp_sml = exp_b;  man_sml = man_b;  sgn_sml = op_q[31];
    end else begin
      exp_big = exp_b;  man_big = man_b;  sgn_big = op_q[31];
      exp_sml = exp_a;  man_sml = man_a;  sgn_sml = acc_q[31];
    end
    exp_diff   = exp_big - exp_sml;
    man_sml_sh = (exp_diff >= 8'd25) ? 24'd0 : (man_sml >> exp_diff);
  end

  // Magnitude add/subtract (evaluated while in ADD)
  logic [24:0] sum_d;
  always_comb begin
    if (sgn_big_q == sgn_sml_q) sum_d = {1'b0, man_big_q} + {1'b0, man_sml_q};
    else                        sum_d = {1'b0, man_big_q - man_sml_q};
  end

  // Normalisation (evaluated while in NORM)
  logic [32:0] norm_d;
  always_comb norm_d = norm_sat(sgn_big_q, exp_big_q, sum_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sgn_big_q   <= 1'b0;
      sgn_sml_q   <= 1'b0;
      exp_big_q   <= 8'd0;
      man_big_q   <= 24'd0;
      man_sml_q   <= 24'd0;
      sum_q       <= 25'd0;
    end else if (enable) begin
      case (state_q)
        // accept: in_ready is high whenever we are here with enable set
        IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.in_data;
            last_q  <= bus.in_last;
            ovf_q   <= ovf_q | bus.in_overflow;
            state_q <= ALIGN;
          end
        end
        // ALIGN -> ADD boundary
        ALIGN: begin
          sgn_big_q <= sgn_big;
          sgn_sml_q <= sgn_sml;
          exp_big_q <= exp_big;
          man_big_q <= man_big;
          man_sml_q <= man_sml_sh;
          state_q   <= ADD;
        end
        // ADD -> NORM boundary
        ADD: begin
          sum_q   <= sum_d;
          state_q <= NORM;
        end
        // NORM -> IDLE/DONE boundary
        NORM: begin
          if (!sat_q) begin
            acc_q <= norm_d[31:0];
            if (norm_d[32]) begin
              sat_q <= 1'b1;
              ovf_q <= 1'b1;
            end
          end
          if (last_q) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = enable & (state_q == IDLE) & ~reset;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = acc_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_fp_accumulator.sv
module tb_fp_accumulator;

  logic clk;
  logic reset;
  logic enable;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  // reference model state
  logic [31:0] m_acc;
  bit          m_ovf;
  bit          m_sat;

  fp_accumulator_if #(.N(32)) bus ();

  fp_accumulator #(.N(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Numeric reference: values are integer significands scaled by 2^(exp-150).
  // The smaller operand is truncated to the larger operand's scale, the signed
  // integers are added, and the result is re-packed from its top set bit.
  function automatic void model_add(input logic [31:0] b);
    longint ma, mb, ml, ms, s, mag;
    int     ea, eb, el, es, msb, e;
    bit     sl, ss;
    if (m_sat) return;
    ea = int'(m_acc[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'sd0 : longint'({1'b1, m_acc[22:0]});
    mb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
    if ((ea > eb) || (ea == eb && ma >= mb)) begin
      ml = ma; el = ea; sl = m_acc[31]; ms = mb; es = eb; ss = b[31];
    end else begin
      ml = mb; el = eb; sl = b[31];     ms = ma; es = ea; ss = m_acc[31];
    end
    if (el - es > 40) ms = 0;
    else              ms = ms >> (el - es);
    s   = (sl ? -ml : ml) + (ss ? -ms : ms);
    mag = (s < 0) ? -s : s;
    if (mag == 0) begin
      m_acc = 32'h0;
      return;
    end
    msb = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) msb = i;
    e = el + msb - 23;
    if (e < 1) begin
      m_acc = 32'h0;
    end else if (e >= 255) begin
      m_acc = {sl, 8'hFF, 23'h0};
      m_sat = 1'b1;
      m_ovf = 1'b1;
    end else begin
      mag   = (msb >= 23) ? (mag >> (msb - 23)) : (mag << (23 - msb));
      m_acc = {sl, 8'(e), mag[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'($urandom_range(245, 254));
    else             e = 8'($urandom_range(120, 135));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Offer one element; returns after the accepting edge (state is then ALIGN).
  task automatic send(input logic [31:0] d, input bit last, input bit ovf);
    int g;
    g = 0;
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_last     = last;
    bus.in_overflow = ovf;
    while (!bus.in_ready && g < 100) begin
      tick();
      g++;
    end
    if (!bus.in_ready) check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.in_overflow = 1'b0;
  endtask

  // Wait for a burst sum, check it, then complete the handshake.
  task automatic recv(input string tag, input logic [31:0] er, input bit eo,
                      input int hold, output int t_vld);
    int g;
    g = 0;
    while (!bus.out_valid && g < 200) begin
      tick();
      g++;
    end
    t_vld = cyc;
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_result"}, bus.result, er);
    check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int t0, tv, nel, gap;
    logic [31:0] d, res_hold;
    bit ov, lst;

    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    enable = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 32'h0;
    bus.in_overflow = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (2) tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1.0 + 2.0 with latency: sum visible 7 edges after the first accepting edge
    send(32'h3F800000, 1'b0, 1'b0);
    t0 = cyc;
    send(32'h40000000, 1'b1, 1'b0);
    recv("add12", 32'h40400000, 1'b0, 0, tv);
    check("add12_latency", 32'(tv - t0), 32'd7);

    // cancellation gives +0
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'hBF800000, 1'b1, 1'b0);
    recv("cancel", 32'h00000000, 1'b0, 0, tv);

    // alignment truncation
    send(32'h4B800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b0);
    recv("trunc", 32'h4B800000, 1'b0, 0, tv);

    // single element
    send(32'h3FC00000, 1'b1, 1'b0);
    recv("single", 32'h3FC00000, 1'b0, 0, tv);

    // saturation, then sticky cleared on the next burst
    send(32'h7F000000, 1'b0, 1'b0);
    send(32'h7F000000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b0);
    recv("sat", 32'h7F800000, 1'b1, 0, tv);
    send(32'h3F800000, 1'b1, 1'b0);
    recv("after_sat", 32'h3F800000, 1'b0, 0, tv);

    // producer overflow flag with a finite sum
    send(32'h40000000, 1'b0, 1'b1);
    send(32'h40000000, 1'b1, 1'b0);
    recv("in_ovf", 32'h40800000, 1'b1, 0, tv);

    // backpressure in DONE
    send(32'h40400000, 1'b1, 1'b0);
    while (!bus.out_valid && cyc < 100000) tick();
    res_hold = bus.result;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_result", bus.result, res_hold);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    recv("bp", 32'h40400000, 1'b0, 0, tv);

    // enable low for 3 cycles during ADD of the first element
    send(32'h3F800000, 1'b0, 1'b0);
    t0 = cyc;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_low_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    enable = 1'b1;
    send(32'h40000000, 1'b1, 1'b0);
    recv("enable", 32'h40400000, 1'b0, 0, tv);
    check("enable_latency", 32'(tv - t0), 32'd10);

    // reset during NORM of a 3-element burst
    send(32'h3F800000, 1'b0, 1'b1);
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("postrst_result", bus.result, 32'h0);
    check("postrst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("postrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    send(32'h40000000, 1'b1, 1'b0);
    recv("postrst", 32'h40000000, 1'b0, 0, tv);

    // randomized bursts against the reference model
    for (int b = 0; b < 40; b++) begin
      m_acc = 32'h0;
      m_ovf = 1'b0;
      m_sat = 1'b0;
      nel = int'($urandom_range(1, 5));
      for (int k = 0; k < nel; k++) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) tick();
        d   = rand_fp();
        ov  = ($urandom_range(0, 9) == 0);
        lst = (k == nel - 1);
        m_ovf = m_ovf | ov;
        model_add(d);
        send(d, lst, ov);
      end
      recv("rand", m_acc, m_ovf, int'($urandom_range(0, 3)), tv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
